// File: rtl/latch_share_ctrl.sv
// Round-robin arbiter that lends one shared D latch (en/d) to NREQ requesters and keeps a registered shadow q.
// Latency: grant edge -> lat_en high HOLD cycles -> 1-cycle ack; back-to-back period HOLD+2.
// Backpressure: losing/late requesters simply wait in req (level) until granted; no abort once granted.
module latch_share_ctrl #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int HOLD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               lat_en,
  output logic [DW-1:0]      lat_d,
  output logic [DW-1:0]      q,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;

  logic          found;
  logic [PW-1:0] idx;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      gnt    <= '0;
      ack    <= '0;
      lat_en <= 1'b0;
      lat_d  <= '0;
      q      <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner  <= idx;
            gnt    <= NREQ'(1) << idx;
            lat_d  <= wdata[idx*DW +: DW];
            lat_en <= 1'b1;
            cnt    <= CW'(HOLD - 1);
            busy   <= 1'b1;
            state  <= OPEN;
          end
        end
        OPEN: begin
          if (cnt == '0) begin
            lat_en <= 1'b0;
            q      <= lat_d;
            ack    <= gnt;
            state  <= CLOSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CLOSE: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (int'(owner) == NREQ - 1) ? '0 : owner + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_share_ctrl.sv
// Directed bench for latch_share_ctrl (NREQ=4, DW=8, HOLD=2): vector table plus round-robin sequences.
module tb_latch_share_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        lat_en;
  logic [7:0]  lat_d;
  logic [7:0]  q;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  latch_share_ctrl #(.NREQ(4), .DW(8), .HOLD(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .lat_en (lat_en),
    .lat_d  (lat_d),
    .q      (q),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        en;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        busy;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [25:0] pk(input logic [3:0] g, input logic [3:0] a, input logic e,
                                     input logic [7:0] d, input logic [7:0] qq, input logic b);
    return {g, a, e, d, qq, b};
  endfunction

  task automatic check(input string name, input logic [25:0] exp);
    logic [25:0] got;
    got = {gnt, ack, lat_en, lat_d, q, busy};
    n_total++;
    if (got !== exp)
      $display("FAIL %s got{gnt,ack,en,d,q,busy}=%h/%h/%b/%h/%h/%b required=%h/%h/%b/%h/%h/%b",
               name, got[25:22], got[21:18], got[17], got[16:9], got[8:1], got[0],
               exp[25:22], exp[21:18], exp[17], exp[16:9], exp[8:1], exp[0]);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                              input logic [3:0] g, input logic [3:0] a, input logic e,
                              input logic [7:0] d, input logic [7:0] qq, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.wdata = wd;
    v.gnt = g; v.ack = a; v.en = e; v.d = d; v.q = qq; v.busy = b;
    return v;
  endfunction

  // owners: packed list of 4 expected owner indices, entry k in bits [2k+:2]
  task automatic run_rr(input string name, input logic [3:0] reqs, input logic [31:0] wd,
                        input logic [7:0] owners, input bit drop);
    logic [7:0] lastq;
    logic [7:0] sl;
    logic [3:0] oh;
    logic [1:0] o;
    int k;
    int ph;
    rst = 1'b1; req = '0; wdata = wd;
    @(posedge clk); #1;
    check({name, "_reset"}, pk(4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0));
    rst = 1'b0; req = reqs;
    lastq = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      k  = (c - 1) / 4;
      ph = (c - 1) % 4;
      o  = owners[2*k +: 2];
      oh = 4'b0001 << o;
      sl = wd[8*o +: 8];
      if (ph < 2) begin
        check($sformatf("%s_c%0d_open", name, c), pk(oh, 4'h0, 1'b1, sl, lastq, 1'b1));
      end else if (ph == 2) begin
        lastq = sl;
        check($sformatf("%s_c%0d_ack", name, c), pk(oh, oh, 1'b0, sl, lastq, 1'b1));
        if (drop) req[o] = 1'b0;
      end else begin
        check($sformatf("%s_c%0d_idle", name, c), pk(4'h0, 4'h0, 1'b0, sl, lastq, 1'b0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; wdata = '0;

    //             rst  req   wdata          gnt   ack   en    d      q      busy
    tbl[0]  = mk(1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
    // single grant to req0
    tbl[1]  = mk(1'b0, 4'h1, 32'h000000A5, 4'h1, 4'h0, 1'b1, 8'hA5, 8'h00, 1'b1);
    tbl[2]  = mk(1'b0, 4'h1, 32'h000000A5, 4'h1, 4'h0, 1'b1, 8'hA5, 8'h00, 1'b1);
    tbl[3]  = mk(1'b0, 4'h1, 32'h000000A5, 4'h1, 4'h1, 1'b0, 8'hA5, 8'hA5, 1'b1);
    tbl[4]  = mk(1'b0, 4'h0, 32'h000000A5, 4'h0, 4'h0, 1'b0, 8'hA5, 8'hA5, 1'b0);
    // data change after grant is ignored
    tbl[5]  = mk(1'b0, 4'h1, 32'h0000005A, 4'h1, 4'h0, 1'b1, 8'h5A, 8'hA5, 1'b1);
    tbl[6]  = mk(1'b0, 4'h1, 32'h0000003C, 4'h1, 4'h0, 1'b1, 8'h5A, 8'hA5, 1'b1);
    tbl[7]  = mk(1'b0, 4'h1, 32'h0000003C, 4'h1, 4'h1, 1'b0, 8'h5A, 8'h5A, 1'b1);
    tbl[8]  = mk(1'b0, 4'h0, 32'h0000003C, 4'h0, 4'h0, 1'b0, 8'h5A, 8'h5A, 1'b0);
    // req2 dropped mid-window still completes
    tbl[9]  = mk(1'b0, 4'h4, 32'h00770000, 4'h4, 4'h0, 1'b1, 8'h77, 8'h5A, 1'b1);
    tbl[10] = mk(1'b0, 4'h0, 32'h00770000, 4'h4, 4'h0, 1'b1, 8'h77, 8'h5A, 1'b1);
    tbl[11] = mk(1'b0, 4'h0, 32'h00770000, 4'h4, 4'h4, 1'b0, 8'h77, 8'h77, 1'b1);
    tbl[12] = mk(1'b0, 4'h0, 32'h00770000, 4'h0, 4'h0, 1'b0, 8'h77, 8'h77, 1'b0);
    // ptr now 3: req0|req2 resolves to 0
    tbl[13] = mk(1'b0, 4'h5, 32'h00340012, 4'h1, 4'h0, 1'b1, 8'h12, 8'h77, 1'b1);
    tbl[14] = mk(1'b0, 4'h5, 32'h00340012, 4'h1, 4'h0, 1'b1, 8'h12, 8'h77, 1'b1);
    tbl[15] = mk(1'b0, 4'h5, 32'h00340012, 4'h1, 4'h1, 1'b0, 8'h12, 8'h12, 1'b1);
    tbl[16] = mk(1'b0, 4'h0, 32'h00340012, 4'h0, 4'h0, 1'b0, 8'h12, 8'h12, 1'b0);
    // reset inside OPEN truncates window, no ack, then regrant
    tbl[17] = mk(1'b0, 4'h1, 32'h000000C3, 4'h1, 4'h0, 1'b1, 8'hC3, 8'h12, 1'b1);
    tbl[18] = mk(1'b0, 4'h1, 32'h000000C3, 4'h1, 4'h0, 1'b1, 8'hC3, 8'h12, 1'b1);
    tbl[19] = mk(1'b1, 4'h1, 32'h000000C3, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
    tbl[20] = mk(1'b0, 4'h1, 32'h000000C3, 4'h1, 4'h0, 1'b1, 8'hC3, 8'h00, 1'b1);
    tbl[21] = mk(1'b0, 4'h1, 32'h000000C3, 4'h1, 4'h0, 1'b1, 8'hC3, 8'h00, 1'b1);
    tbl[22] = mk(1'b0, 4'h1, 32'h000000C3, 4'h1, 4'h1, 1'b0, 8'hC3, 8'hC3, 1'b1);
    tbl[23] = mk(1'b0, 4'h0, 32'h000000C3, 4'h0, 4'h0, 1'b0, 8'hC3, 8'hC3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; wdata = tbl[i].wdata;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            pk(tbl[i].gnt, tbl[i].ack, tbl[i].en, tbl[i].d, tbl[i].q, tbl[i].busy));
    end

    // all four requesting, each drops after its ack: owners 0,1,2,3
    run_rr("rr_all", 4'hF, 32'h44332211, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
    // req0 and req2 held forever: owners alternate 0,2,0,2
    run_rr("rr_02", 4'h5, 32'h00BB00AA, {2'd2, 2'd0, 2'd2, 2'd0}, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
